// File: rtl/core_load_store_unit_if.sv
// Core-side request/response bundle of the load/store unit.
// The slave modport is the LSU; the master modport is the issuing core stage.
interface core_load_store_unit_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  req_i;
  logic                  is_store_i;
  logic [2:0]            funct3_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [31:0]           wdata_i;
  logic [31:0]           rdata_o;
  logic                  done_o;
  logic                  busy_o;
  logic                  misaligned_o;

  modport master (
    output req_i, is_store_i, funct3_i, addr_i, wdata_i,
    input  rdata_o, done_o, busy_o, misaligned_o
  );

  modport slave (
    input  req_i, is_store_i, funct3_i, addr_i, wdata_i,
    output rdata_o, done_o, busy_o, misaligned_o
  );
endinterface

// File: rtl/core_load_store_unit.sv
// RV32I load/store unit over a word-wide synchronous-read data memory.
// Optional LSU_BYTE_ENABLE_EN: byte-lane write enables replace read-modify-write for SB/SH.
module core_load_store_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  core_load_store_unit_if.slave lsu_if,
  output logic                  we_mem_data_o,
  output logic [ADDR_WIDTH-3:0] addr_mem_data_o,
  input  logic [DATA_WIDTH-1:0] val_mem_data_read_i,
  output logic [DATA_WIDTH-1:0] val_mem_data_write_o
`ifdef LSU_BYTE_ENABLE_EN
  ,
  output logic [3:0]            be_mem_data_o
`endif
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_CAP,
    S_DONE,
    S_ERR
  } state_e;

`ifdef LSU_BYTE_ENABLE_EN
  localparam state_e SUBWORD_STORE_FIRST = S_WR;
`else
  localparam state_e SUBWORD_STORE_FIRST = S_RD;
`endif

  state_e                state_q;
  logic [1:0]            off_q;
  logic [2:0]            funct3_q;
  logic                  is_store_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-3:0] mem_addr_q;

  logic                  access_ok_d;
  logic [7:0]            lane_byte_d;
  logic [15:0]           lane_half_d;
  logic [DATA_WIDTH-1:0] load_ext_d;
  logic [DATA_WIDTH-1:0] store_word_d;
`ifdef LSU_BYTE_ENABLE_EN
  logic [3:0]            be_d;
`endif

  always_comb begin
    access_ok_d = 1'b0;
    case (lsu_if.funct3_i)
      F3_B:    access_ok_d = 1'b1;
      F3_H:    access_ok_d = !lsu_if.addr_i[0];
      F3_W:    access_ok_d = (lsu_if.addr_i[1:0] == 2'b00);
      F3_BU:   access_ok_d = !lsu_if.is_store_i;
      F3_HU:   access_ok_d = !lsu_if.is_store_i && !lsu_if.addr_i[0];
      default: access_ok_d = 1'b0;
    endcase
  end

  always_comb begin
    lane_byte_d = val_mem_data_read_i[{off_q, 3'b000} +: 8];
    lane_half_d = off_q[1] ? val_mem_data_read_i[31:16] : val_mem_data_read_i[15:0];
    case (funct3_q)
      F3_B:    load_ext_d = {{24{lane_byte_d[7]}}, lane_byte_d};
      F3_H:    load_ext_d = {{16{lane_half_d[15]}}, lane_half_d};
      F3_BU:   load_ext_d = {24'd0, lane_byte_d};
      F3_HU:   load_ext_d = {16'd0, lane_half_d};
      default: load_ext_d = val_mem_data_read_i;
    endcase
  end

`ifdef LSU_BYTE_ENABLE_EN
  always_comb begin
    case (funct3_q)
      F3_B: begin
        store_word_d = {4{wdata_q[7:0]}};
        be_d         = 4'b0001 << off_q;
      end
      F3_H: begin
        store_word_d = {2{wdata_q[15:0]}};
        be_d         = off_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_word_d = wdata_q;
        be_d         = 4'b1111;
      end
    endcase
  end
`else
  // Read data in WR is the word fetched during RD, so the merge is combinational.
  always_comb begin
    store_word_d = val_mem_data_read_i;
    case (funct3_q)
      F3_B: store_word_d[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      F3_H: begin
        if (off_q[1]) store_word_d[31:16] = wdata_q[15:0];
        else          store_word_d[15:0]  = wdata_q[15:0];
      end
      default: store_word_d = wdata_q;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      off_q      <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lsu_if.req_i) begin
            off_q      <= lsu_if.addr_i[1:0];
            funct3_q   <= lsu_if.funct3_i;
            is_store_q <= lsu_if.is_store_i;
            wdata_q    <= lsu_if.wdata_i;
            mem_addr_q <= lsu_if.addr_i[ADDR_WIDTH-1:2];
            if (!access_ok_d)                   state_q <= S_ERR;
            else if (!lsu_if.is_store_i)        state_q <= S_RD;
            else if (lsu_if.funct3_i == F3_W)   state_q <= S_WR;
            else                                state_q <= SUBWORD_STORE_FIRST;
          end
        end
        S_RD:    state_q <= is_store_q ? S_WR : S_CAP;
        S_CAP: begin
          rdata_q <= load_ext_d;
          state_q <= S_DONE;
        end
        S_WR:    state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lsu_if.busy_o        = (state_q != S_IDLE);
  assign lsu_if.done_o        = (state_q == S_DONE) || (state_q == S_ERR);
  assign lsu_if.misaligned_o  = (state_q == S_ERR);
  assign lsu_if.rdata_o       = rdata_q;
  assign we_mem_data_o        = (state_q == S_WR);
  assign addr_mem_data_o      = mem_addr_q;
  assign val_mem_data_write_o = (state_q == S_WR) ? store_word_d : '0;
`ifdef LSU_BYTE_ENABLE_EN
  assign be_mem_data_o        = (state_q == S_WR) ? be_d : 4'b0000;
`endif

endmodule

// File: tb/tb_core_load_store_unit.sv
// Bench for core_load_store_unit: per-cycle comparison against a queue of expected
// output records produced by an access-level model, plus literal spot checks.
module tb_core_load_store_unit;

  localparam int AW = 10;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        mis;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  maddr;
    logic [31:0] rdata;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we;
  logic [7:0]  maddr;
  logic [31:0] mem_rd;
  logic [31:0] mem_wr;
  logic [3:0]  be_act;

  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_val = '0;

  logic [31:0] exp_mem [0:255];
  rec_t        exp_q[$];
  logic [7:0]  m_maddr = '0;
  logic [31:0] m_rdata = '0;
  logic [7:0]  last_maddr = '0;
  logic [31:0] last_rdata = '0;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  core_load_store_unit_if #(.ADDR_WIDTH(AW)) lsu_if ();

  core_load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .lsu_if               (lsu_if),
    .we_mem_data_o        (we),
    .addr_mem_data_o      (maddr),
    .val_mem_data_read_i  (mem_rd),
    .val_mem_data_write_o (mem_wr)
`ifdef LSU_BYTE_ENABLE_EN
    ,
    .be_mem_data_o        (be_act)
`endif
  );

`ifndef LSU_BYTE_ENABLE_EN
  assign be_act = 4'b0000;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_val;
    else if (we) begin
`ifdef LSU_BYTE_ENABLE_EN
      for (int k = 0; k < 4; k++)
        if (be_act[k]) mem[maddr][8*k +: 8] <= mem_wr[8*k +: 8];
`else
      mem[maddr] <= mem_wr;
`endif
    end
    mem_rd <= mem[maddr];
  end

  // Per-cycle comparison; an empty queue means the unit must be idle.
  always @(negedge clk) begin
    rec_t e;
    rec_t a;
    cyc++;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
        e = '0;
        e.maddr = last_maddr;
        e.rdata = last_rdata;
      end
      last_maddr = e.maddr;
      last_rdata = e.rdata;
      a = {lsu_if.busy_o, lsu_if.done_o, lsu_if.misaligned_o, we, be_act, mem_wr, maddr, lsu_if.rdata_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_%0d got busy=%b done=%b mis=%b we=%b be=%b wdata=%h maddr=%h rdata=%h want busy=%b done=%b mis=%b we=%b be=%b wdata=%h maddr=%h rdata=%h",
                 cyc, a.busy, a.done, a.mis, a.we, a.be, a.wdata, a.maddr, a.rdata,
                 e.busy, e.done, e.mis, e.we, e.be, e.wdata, e.maddr, e.rdata);
      end
    end
  end

  function automatic rec_t idle_rec();
    rec_t r;
    r = '0;
    r.maddr = m_maddr;
    r.rdata = m_rdata;
    return r;
  endfunction

  // Expected records for cycles N (request visible) through the completion cycle.
  task automatic model_access(input bit st, input logic [2:0] f3, input int addr, input logic [31:0] wd);
    rec_t r;
    bit ok;
    int word, off, lat;
    logic [31:0] old, val, mask, newv, wout;
    logic [3:0] bemask;
    word = addr / 4;
    off  = addr % 4;
    ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (f3[1:0] == 2'd1 && (addr % 2) != 0) ok = 1'b0;
    if (f3[1:0] == 2'd2 && off != 0) ok = 1'b0;
    exp_q.push_back(idle_rec());
    m_maddr = word[7:0];
    old = exp_mem[word];
    if (!ok) begin
      r = idle_rec(); r.busy = 1; r.done = 1; r.mis = 1;
      exp_q.push_back(r);
    end else if (!st) begin
      val = old >> (8 * off);
      case (f3)
        3'd0: val = {{24{val[7]}}, val[7:0]};
        3'd1: val = {{16{val[15]}}, val[15:0]};
        3'd4: val = val & 32'h0000_00FF;
        3'd5: val = val & 32'h0000_FFFF;
        default: val = old;
      endcase
      r = idle_rec(); r.busy = 1;
      exp_q.push_back(r);
      exp_q.push_back(r);
      m_rdata = val;
      r = idle_rec(); r.busy = 1; r.done = 1;
      exp_q.push_back(r);
    end else begin
      mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      newv = (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      exp_mem[word] = newv;
`ifdef LSU_BYTE_ENABLE_EN
      lat    = 2;
      wout   = (f3 == 3'd0) ? {4{wd[7:0]}} : (f3 == 3'd1) ? {2{wd[15:0]}} : wd;
      bemask = (f3 == 3'd0) ? (4'b0001 << off) : (f3 == 3'd1) ? (4'b0011 << off) : 4'b1111;
`else
      lat    = (f3 == 3'd2) ? 2 : 3;
      wout   = newv;
      bemask = 4'b0000;
`endif
      for (int i = 1; i <= lat; i++) begin
        r = idle_rec(); r.busy = 1;
        if (i == lat - 1) begin r.we = 1; r.wdata = wout; r.be = bemask; end
        if (i == lat) r.done = 1;
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  task automatic drive(input bit st, input logic [2:0] f3, input int addr, input logic [31:0] wd);
    lsu_if.req_i      = 1'b1;
    lsu_if.is_store_i = st;
    lsu_if.funct3_i   = f3;
    lsu_if.addr_i     = addr[AW-1:0];
    lsu_if.wdata_i    = wd;
  endtask

  task automatic issue(input bit st, input logic [2:0] f3, input int addr, input logic [31:0] wd);
    @(posedge clk); #1;
    drive(st, f3, addr, wd);
    model_access(st, f3, addr, wd);
    @(posedge clk); #1;
    lsu_if.req_i = 1'b0;
    wait_drain();
  endtask

  task automatic preload(input int word, input logic [31:0] val);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = word[7:0]; pl_val = val;
    exp_mem[word] = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    rec_t r;
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    lsu_if.req_i = 1'b0; lsu_if.is_store_i = 1'b0; lsu_if.funct3_i = '0;
    lsu_if.addr_i = '0; lsu_if.wdata_i = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Plain word store
    issue(1'b1, 3'b010, 'h010, 32'hDEADBEEF);
    check32("sw_mem", mem[4], 32'hDEADBEEF);
    $display("SW  0x010 mem[4]=%h", mem[4]);

    // Loads with every extension flavour
    preload(4, 32'h8070F0A5);
    issue(1'b0, 3'b000, 'h011, 0); check32("lb_rdata", lsu_if.rdata_o, 32'hFFFFFFF0);
    $display("LB  0x011 rdata=%h", lsu_if.rdata_o);
    issue(1'b0, 3'b100, 'h013, 0); check32("lbu_rdata", lsu_if.rdata_o, 32'h00000080);
    $display("LBU 0x013 rdata=%h", lsu_if.rdata_o);
    issue(1'b0, 3'b001, 'h012, 0); check32("lh_rdata", lsu_if.rdata_o, 32'hFFFF8070);
    $display("LH  0x012 rdata=%h", lsu_if.rdata_o);
    issue(1'b0, 3'b101, 'h010, 0); check32("lhu_rdata", lsu_if.rdata_o, 32'h0000F0A5);
    $display("LHU 0x010 rdata=%h", lsu_if.rdata_o);
    issue(1'b0, 3'b010, 'h010, 0); check32("lw_rdata", lsu_if.rdata_o, 32'h8070F0A5);
    $display("LW  0x010 rdata=%h", lsu_if.rdata_o);

    // Sub-word stores
    issue(1'b1, 3'b000, 'h012, 32'h123456CC);
    check32("sb_model", exp_mem[4], 32'h80CCF0A5);
    check32("sb_mem", mem[4], 32'h80CCF0A5);
    $display("SB  0x012 mem[4]=%h", mem[4]);
    preload(4, 32'h8070F0A5);
    issue(1'b1, 3'b001, 'h010, 32'h0000BEEF);
    check32("sh_mem", mem[4], 32'h8070BEEF);
    $display("SH  0x010 mem[4]=%h", mem[4]);

    // Rejected accesses leave rdata and memory alone
    issue(1'b0, 3'b010, 'h012, 0);
    $display("LW  0x012 rejected");
    issue(1'b1, 3'b001, 'h011, 32'h0000AAAA);
    $display("SH  0x011 rejected");
    issue(1'b0, 3'b011, 'h010, 0);
    $display("LD? 0x010 rejected");
    check32("err_rdata_hold", lsu_if.rdata_o, 32'h8070F0A5);
    check32("err_mem_hold", mem[4], 32'h8070BEEF);

    // Back-to-back loads with req held high
    preload(5, 32'h13572468);
    @(posedge clk); #1;
    drive(1'b0, 3'b010, 'h010, 0);
    model_access(1'b0, 3'b010, 'h010, 0);
    model_access(1'b0, 3'b010, 'h014, 0);
    @(posedge clk); #1;
    lsu_if.addr_i = 10'h014;
    repeat (5) @(posedge clk);
    #1 lsu_if.req_i = 1'b0;
    wait_drain();
    check32("b2b_rdata", lsu_if.rdata_o, 32'h13572468);
    $display("LW  b2b rdata=%h", lsu_if.rdata_o);

    // Reset in the RD cycle of an SB
    preload(4, 32'h8070F0A5);
    @(posedge clk); #1;
    drive(1'b1, 3'b000, 'h012, 32'h000000CC);
    exp_q.push_back(idle_rec());
    m_maddr = 8'd4;
    r = idle_rec(); r.busy = 1;
    exp_q.push_back(r);
    exp_q.push_back('0);
    m_maddr = '0;
    m_rdata = '0;
    @(posedge clk); #1;
    lsu_if.req_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    check32("rst_mem_hold", mem[4], 32'h8070F0A5);
    check32("rst_rdata", lsu_if.rdata_o, 32'h00000000);
    $display("SB  reset mid-access mem[4]=%h", mem[4]);

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_load_store_unit.md
Name: core_load_store_unit

Overview:
Load/store stage downstream of the RV32I execution unit, between the core's computed data address/store value and the word-wide data memory. Performs all RV32I loads and stores on a 32-bit word memory: lane selection, sign/zero extension, alignment checking. Sub-word stores are done as read-modify-write. Uses a req/busy/done handshake so the core can stall on memory access.

Parameters:
ADDR_WIDTH, 10, byte-address width of addr_i; memory word address is ADDR_WIDTH-2 bits
DATA_WIDTH, 32, data width; only 32 is supported

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
req_i  input  1  access request; sampled only when busy_o=0
is_store_i  input  1  1=store, 0=load
funct3_i  input  3  RV32I funct3 of the load/store
addr_i  input  ADDR_WIDTH  byte address
wdata_i  input  32  store data (low byte/half used for SB/SH)
rdata_o  output  32  extended load result; held until the next load completes
done_o  output  1  one-cycle completion pulse
busy_o  output  1  access in progress
misaligned_o  output  1  with done_o: access rejected (misaligned or illegal funct3)
we_mem_data_o  output  1  data memory write enable
addr_mem_data_o  output  ADDR_WIDTH-2  data memory word address
val_mem_data_read_i  input  32  memory read data; synchronous read, valid one cycle after address
val_mem_data_write_o  output  32  memory write data

Behaviour:
- Reset: rst_n low at an edge -> state IDLE. rdata_o, addr_mem_data_o, val_mem_data_write_o = 0. done_o, busy_o, misaligned_o, we_mem_data_o = 0.
- Accept: in IDLE with req_i=1 (cycle N), latch addr, funct3, is_store and wdata. req_i is ignored while busy_o=1.
- busy_o = (state != IDLE). The next request can be accepted in the cycle after DONE/ERR.
- Legal funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
  - anything else is illegal.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
- States: IDLE, RD, WR, CAP, DONE, ERR.
  - Illegal/misaligned: IDLE->ERR. ERR in N+1: done_o=1, misaligned_o=1, no memory access, rdata_o unchanged. ERR->IDLE.
  - Load: IDLE->RD (N+1, address out) ->CAP (N+2, extract val_mem_data_read_i into rdata register) ->DONE (N+3, done_o=1). Latency 3.
  - SW: IDLE->WR (N+1, we=1, data=wdata) ->DONE (N+2).
  - SB/SH: IDLE->RD (N+1) ->WR (N+2, we=1, data = read word with addressed lane(s) replaced by wdata low bits) ->DONE (N+3).
- addr_mem_data_o = latched addr[ADDR_WIDTH-1:2]; holds its value outside an access.
- we_mem_data_o = 1 only in WR. val_mem_data_write_o = 0 outside WR.
- Lanes are little-endian: byte k = bits [8k+7:8k]; halfword at addr[1].
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- DONE/ERR always return to IDLE. Only one access is ever outstanding.
- Reset mid-operation: the FSM goes to IDLE next cycle; no further write is issued and done_o is not pulsed. A write already driven in the current cycle is not retracted.

Optional Feature:
LSU_BYTE_ENABLE_EN
- Defined:
  - Adds output be_mem_data_o[3:0], byte-lane write enables, valid with we_mem_data_o and 0 otherwise.
  - SB/SH skip RD and write directly with wdata replicated to the lanes: IDLE->WR->DONE, latency 2.
  - SW uses be=1111.
- Undefined: port absent; sub-word stores use read-modify-write (latency 3).

Test Plan:
1. SW addr 0x010, wdata 0xDEADBEEF -> N+1 we=1, addr_mem=4, data 0xDEADBEEF; N+2 done_o=1, misaligned_o=0.
2. Mem[4]=0x8070F0A5; LB 0x011 -> 0xFFFFFFF0; LBU 0x013 -> 0x00000080; LH 0x012 -> 0xFFFF8070; LHU 0x010 -> 0x0000F0A5; LW 0x010 -> 0x8070F0A5. Each has done_o at N+3.
3. Mem[4]=0x8070F0A5; SB 0x012, wdata 0x123456CC -> N+2 write 0x80CCF0A5, done N+3. SH 0x010, wdata 0xBEEF -> write 0x8070BEEF. With LSU_BYTE_ENABLE_EN: be=0100, write at N+1, done N+2.
4. LW 0x012, SH 0x011, and load funct3=011 -> each gives done_o=1 and misaligned_o=1 at N+1, we never asserted, rdata_o unchanged.
5. req_i held high for 6 cycles with back-to-back LW -> second request accepted in the cycle after the first DONE; busy_o low only in that IDLE cycle.
6. rst_n low during RD of an SB -> next cycle IDLE, all outputs 0, we_mem_data_o never asserted, no done_o.
